// File: rtl/matrix_loader.sv
// Byte-stream sequencer for the 3x4 matrix register bank: column-major writes
// through a registered data bus plus one-hot load strobe, then holds until consumed.
module matrix_loader #(
  parameter int DATA_W    = 8,
  parameter int NUM_ELEMS = 12
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 start,
  input  logic                 consume,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATA_W-1:0]    din,
  output logic [NUM_ELEMS-1:0] load,
  output logic [3:0]           elem_idx,
  output logic                 busy,
  output logic                 full
);

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_e;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ELEMS - 1);

  state_e                 state_q;
  logic [DATA_W-1:0]      din_q;
  logic [NUM_ELEMS-1:0]   load_q;
  logic [3:0]             idx_q;
  logic [NUM_ELEMS-1:0]   load_d;

  assign load_d = NUM_ELEMS'(1) << idx_q;

  always_ff @(posedge clk) begin
    if (aclr) begin
      state_q <= IDLE;
      din_q   <= '0;
      load_q  <= '0;
      idx_q   <= '0;
    end else begin
      // Strobe is a single-cycle pulse; din is left alone unless a byte lands.
      load_q <= '0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= LOAD;
          idx_q   <= '0;
        end
        LOAD: if (in_valid) begin
          din_q  <= in_data;
          load_q <= load_d;
          if (idx_q == LAST_IDX) state_q <= FULL;
          else                   idx_q   <= idx_q + 4'd1;
        end
        FULL: begin
          if (start) begin
            state_q <= LOAD;
            idx_q   <= '0;
          end else if (consume) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready = (state_q == LOAD);
  assign busy     = (state_q == LOAD);
  assign full     = (state_q == FULL);
  assign din      = din_q;
  assign load     = load_q;
  assign elem_idx = idx_q;

endmodule
